// File: rtl/rev_add_lifo.sv
// rev_add_lifo: WIDTH-bit reversible add/un-add unit with a LIFO history of forward results.
// Define REV_CHECK_EN to keep shadow operands per entry and raise a sticky chk_err on bad recovery.
module rev_add_lifo #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 4,
  parameter int TURN_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_dir,
  input  logic [WIDTH-1:0]             cmd_a,
  input  logic [WIDTH-1:0]             cmd_b,
  input  logic                         cmd_c0,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_dir,
  output logic [WIDTH-1:0]             rsp_s,
  output logic                         rsp_cout,
  output logic [WIDTH-1:0]             rsp_a,
  output logic [WIDTH-1:0]             rsp_b,
  output logic                         rsp_c0,
  output logic                         rsp_z,
  output logic                         rsp_err,
  output logic                         cur_dir,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         chk_err
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(TURN_CYCLES + 1);

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_TURN = 2'd2} state_t;

  function automatic logic [WIDTH:0] core_fwd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic c0);
    core_fwd = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c0};
  endfunction

  function automatic logic core_carry(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                      input logic c0);
    logic [WIDTH:0] t;
    t = core_fwd(a, b, c0);
    core_carry = t[WIDTH];
  endfunction

  function automatic logic [WIDTH-1:0] core_rev_b(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] a_b,
                                                  input logic c0_b);
    core_rev_b = s - a_b - {{(WIDTH-1){1'b0}}, c0_b};
  endfunction

  state_t            state_r, state_s;
  logic [CW-1:0]     cnt_r;
  logic              cur_dir_r;
  logic [LW-1:0]     level_r;
  logic [WIDTH-1:0]  stk_s_r    [DEPTH];
  logic [WIDTH-1:0]  stk_a_r    [DEPTH];
  logic              stk_c0_r   [DEPTH];
  logic              stk_cout_r [DEPTH];
`ifdef REV_CHECK_EN
  logic [WIDTH-1:0]  stk_oa_r   [DEPTH];
  logic [WIDTH-1:0]  stk_ob_r   [DEPTH];
  logic              chk_err_r;
`endif

  logic              accept_s, full_s, empty_s, push_s, pop_s;
  logic [IW-1:0]     top_idx_s, push_idx_s;
  logic [WIDTH:0]    fwd_sum_s;
  logic [WIDTH-1:0]  pop_s_s, pop_a_s, rec_b_s;
  logic              pop_c0_s, pop_cout_s, rec_z_s;
  logic [WIDTH-1:0]  nxt_s_s, nxt_a_s, nxt_b_s;
  logic              nxt_cout_s, nxt_c0_s, nxt_z_s, nxt_err_s;

  assign cur_dir    = cur_dir_r;
  assign level      = level_r;
  assign accept_s   = cmd_valid && cmd_ready;
  assign full_s     = (level_r == LW'(DEPTH));
  assign empty_s    = (level_r == '0);
  assign push_s     = accept_s && !cmd_dir && !full_s;
  assign pop_s      = accept_s && cmd_dir && !empty_s;
  assign push_idx_s = IW'(level_r);

  // Top-of-stack pointer, pinned to entry 0 when empty so reads stay in range
  always_comb begin
    top_idx_s = '0;
    if (!empty_s) top_idx_s = IW'(level_r - LW'(1));
    else          top_idx_s = '0;
  end

  // Forward core on the command operands and reverse core on the top entry
  always_comb begin
    fwd_sum_s  = core_fwd(cmd_a, cmd_b, cmd_c0);
    pop_s_s    = stk_s_r[top_idx_s];
    pop_a_s    = stk_a_r[top_idx_s];
    pop_c0_s   = stk_c0_r[top_idx_s];
    pop_cout_s = stk_cout_r[top_idx_s];
    rec_b_s    = core_rev_b(pop_s_s, pop_a_s, pop_c0_s);
    rec_z_s    = pop_cout_s ^ core_carry(pop_a_s, rec_b_s, pop_c0_s);
  end

  // Response payload for a command accepted this cycle; error responses carry no data
  always_comb begin
    nxt_s_s = '0; nxt_a_s = '0; nxt_b_s = '0;
    nxt_cout_s = 1'b0; nxt_c0_s = 1'b0; nxt_z_s = 1'b0; nxt_err_s = 1'b0;
    if (!cmd_dir) begin
      if (full_s) begin
        nxt_err_s = 1'b1;
      end else begin
        nxt_s_s    = fwd_sum_s[WIDTH-1:0];
        nxt_cout_s = fwd_sum_s[WIDTH] ^ 1'b0;
      end
    end else begin
      if (empty_s) begin
        nxt_err_s = 1'b1;
      end else begin
        nxt_a_s  = pop_a_s;
        nxt_b_s  = rec_b_s;
        nxt_c0_s = pop_c0_s;
        nxt_z_s  = rec_z_s;
      end
    end
  end

  // FSM next state: a direction change drains the response slot, then idles TURN_CYCLES
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_RUN:   if (cmd_valid && (cmd_dir != cur_dir_r)) state_s = ST_DRAIN; else state_s = ST_RUN;
      ST_DRAIN: if (!rsp_valid) state_s = ST_TURN; else state_s = ST_DRAIN;
      ST_TURN:  if (cnt_r <= CW'(1)) state_s = ST_RUN; else state_s = ST_TURN;
      default:  state_s = ST_RUN;
    endcase
  end

  // FSM output: accept only in the enabled direction with a free response slot
  always_comb begin
    cmd_ready = 1'b0;
    if (rst_n && (state_r == ST_RUN) && (cmd_dir == cur_dir_r) && (!rsp_valid || rsp_ready)) cmd_ready = 1'b1;
    else cmd_ready = 1'b0;
  end

  // FSM state, turnaround counter and enabled direction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_RUN;
      cnt_r     <= '0;
      cur_dir_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if ((state_r == ST_DRAIN) && !rsp_valid)     cnt_r <= CW'(TURN_CYCLES);
      else if ((state_r == ST_TURN) && (cnt_r != '0)) cnt_r <= cnt_r - CW'(1);
      else                                          cnt_r <= cnt_r;
      if ((state_r == ST_TURN) && (state_s == ST_RUN)) cur_dir_r <= ~cur_dir_r;
      else                                             cur_dir_r <= cur_dir_r;
    end
  end

  // LIFO storage and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        stk_s_r[i]    <= '0;
        stk_a_r[i]    <= '0;
        stk_c0_r[i]   <= 1'b0;
        stk_cout_r[i] <= 1'b0;
`ifdef REV_CHECK_EN
        stk_oa_r[i]   <= '0;
        stk_ob_r[i]   <= '0;
`endif
      end
    end else if (push_s) begin
      stk_s_r[push_idx_s]    <= fwd_sum_s[WIDTH-1:0];
      stk_a_r[push_idx_s]    <= cmd_a;
      stk_c0_r[push_idx_s]   <= cmd_c0;
      stk_cout_r[push_idx_s] <= fwd_sum_s[WIDTH];
`ifdef REV_CHECK_EN
      stk_oa_r[push_idx_s]   <= cmd_a;
      stk_ob_r[push_idx_s]   <= cmd_b;
`endif
      level_r <= level_r + LW'(1);
    end else if (pop_s) begin
      level_r <= level_r - LW'(1);
    end else begin
      level_r <= level_r;
    end
  end

  // Single response register, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0; rsp_dir <= 1'b0; rsp_s <= '0; rsp_cout <= 1'b0;
      rsp_a <= '0; rsp_b <= '0; rsp_c0 <= 1'b0; rsp_z <= 1'b0; rsp_err <= 1'b0;
    end else if (accept_s) begin
      rsp_valid <= 1'b1; rsp_dir <= cmd_dir; rsp_s <= nxt_s_s; rsp_cout <= nxt_cout_s;
      rsp_a <= nxt_a_s; rsp_b <= nxt_b_s; rsp_c0 <= nxt_c0_s; rsp_z <= nxt_z_s; rsp_err <= nxt_err_s;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= rsp_valid;
    end
  end

`ifdef REV_CHECK_EN
  // Sticky flag when a pop fails to reproduce the original operands or leaves z set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err_r <= 1'b0;
    end else if (pop_s && ((pop_a_s != stk_oa_r[top_idx_s]) || (rec_b_s != stk_ob_r[top_idx_s]) || rec_z_s)) begin
      chk_err_r <= 1'b1;
    end else begin
      chk_err_r <= chk_err_r;
    end
  end
  assign chk_err = chk_err_r;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: doc/rev_add_lifo.md
Name: rev_add_lifo

Overview:
- Parametrised successor of the 16-bit bidirectional reversible adder: a WIDTH-bit reversible add/un-add unit with registered handshakes and an internal LIFO history of forward results.
- Forward commands compute the sum and push the reversible outputs (sum, operand copy, carry-in copy, carry-out) onto the stack.
- Backward commands pop the top entry and run the core in reverse to recover the original operands and ancilla.
- The block sits between pipeline stage control and the reversible datapath. Direction changes go through an explicit drain/turnaround sequence, so the core is never driven from both sides.

Parameters:
- WIDTH, 16, operand/sum width in bits (>=2).
- DEPTH, 4, LIFO entries (>=1). Each entry holds s, a_b, c0_b and cout.
- TURN_CYCLES, 2, dead cycles inserted on a direction change (>=1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at the edge.
- cmd_dir  in  1  0 = forward (compute and push), 1 = backward (pop and un-compute).
- cmd_a  in  WIDTH  forward operand A; ignored when cmd_dir=1.
- cmd_b  in  WIDTH  forward operand B; ignored when cmd_dir=1.
- cmd_c0  in  1  forward carry-in; ignored when cmd_dir=1.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at the edge.
- rsp_dir  out  1  direction of the command that produced this response.
- rsp_s  out  WIDTH  forward sum; 0 for backward responses.
- rsp_cout  out  1  forward carry-out (ancilla z=0); 0 for backward responses.
- rsp_a  out  WIDTH  backward recovered A; 0 for forward responses.
- rsp_b  out  WIDTH  backward recovered B; 0 for forward responses.
- rsp_c0  out  1  backward recovered carry-in; 0 for forward responses.
- rsp_z  out  1  backward recovered ancilla; expected 0.
- rsp_err  out  1  overflow (forward on full) or underflow (backward on empty).
- cur_dir  out  1  direction currently enabled.
- level  out  $clog2(DEPTH+1)  stack occupancy.
- chk_err  out  1  sticky reversibility-check error (only when REV_CHECK_EN is defined, else tied 0).

Behaviour:
- Reset values: all rsp_* = 0, rsp_valid = 0, cmd_ready = 0 during reset, cur_dir = 0, level = 0, chk_err = 0, FSM = RUN.
- Core arithmetic, forward: s = (a+b+c0) mod 2^WIDTH; a_b = a; c0_b = c0; cout = carry-out XOR z, with z = 0.
- Core arithmetic, backward: a = a_b; b = (s - a_b - c0_b) mod 2^WIDTH; c0 = c0_b; z = cout XOR carry(a, b, c0).
- FSM RUN:
  - cmd_ready = 1 when (cmd_dir == cur_dir) and the response slot is empty or being consumed this cycle.
  - A valid command with cmd_dir != cur_dir holds cmd_ready = 0 and moves the FSM to DRAIN.
- FSM DRAIN: cmd_ready = 0. When rsp_valid = 0, go to TURN and load the counter with TURN_CYCLES.
- FSM TURN:
  - cmd_ready = 0; counter decrements each cycle.
  - At 0: flip cur_dir and go to RUN. The pending command is accepted on the first RUN cycle or later.
- Latency: command accepted at edge N produces rsp_valid high after edge N (visible in cycle N+1). Single response register; back-to-back throughput is 1 per cycle while rsp_ready = 1.
- Response register holds its contents stable while rsp_valid && !rsp_ready.
- Forward with level == DEPTH: accepted; response has rsp_err = 1 and all data 0; no push.
- Backward with level == 0: accepted; response has rsp_err = 1 and all data 0; no pop.
- Push and pop are LIFO. level increments on a valid push and decrements on a valid pop; it never wraps.
- cmd_dir, cmd_a, cmd_b and cmd_c0 must be held stable while cmd_valid && !cmd_ready.
- Reset mid-operation (any FSM state): the stack is discarded, level = 0, cur_dir = 0, and no response is emitted.

Optional Feature:
- Macro: REV_CHECK_EN.
- Defined:
  - Each stack entry also stores the original a and b.
  - On every non-error pop, the recovered a and b are compared with the stored copies, and rsp_z is checked to be 0.
  - Any mismatch sets chk_err, which stays set until reset.
- Undefined: no shadow storage and chk_err is tied 0.

Test Plan:
1. WIDTH=16, DEPTH=4, TURN_CYCLES=2. Forward a=0x1234, b=0x0FFF, c0=1 -> next cycle rsp_s=0x2234, rsp_cout=0, rsp_err=0, level=1.
2. Forward a=0xFFFF, b=0x0001, c0=0 -> rsp_s=0x0000, rsp_cout=1. Then backward -> rsp_a=0xFFFF, rsp_b=0x0001, rsp_c0=0, rsp_z=0, level=0.
3. Push (1,2,0), (3,4,1), (5,6,0), then 3 backward commands -> responses recover (5,6,0), (3,4,1), (1,2,0) in that order. cmd_ready stays low through DRAIN plus exactly 2 TURN cycles before the first pop.
4. After reset, backward on empty -> accepted, rsp_err=1, all data 0, level=0, cur_dir=1. Five forwards -> the 5th gives rsp_err=1 and level stays 4.
5. Hold rsp_ready=0 for 3 cycles with a forward response pending -> rsp_* stable and cmd_ready=0. Release -> next command accepted the same cycle.
6. With REV_CHECK_EN: force a stored a_b bit flip, then pop -> chk_err=1 and stays 1. Assert rst_n=0 during TURN -> cur_dir=0, level=0, rsp_valid=0, chk_err=0.
